// File: rtl/rr_onehot_arbiter_pkg.sv
// ---------------------------------------------------------------------------------------------
// arb_pkg: shared definitions for the round-robin one-hot arbiter slice.
//
// Contents:
//   arb_state_e  - arbiter FSM state {IDLE, GRANT}
//   DefaultN     - default requester count (matches the 4-input downstream encoder)
//   DefaultMaxHold - default grant hold limit used when ARB_TIMEOUT_EN is defined
//   MaxN         - largest supported requester count
//   onehot_of()  - index -> MaxN-bit one-hot vector; callers truncate to their own width
// ---------------------------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultN       = 4;
    localparam int unsigned DefaultMaxHold = 8;
    localparam int unsigned MaxN           = 16;

    // Returns a vector with only bit idx set. Indices beyond MaxN-1 yield all zeros.
    function automatic logic [MaxN-1:0] onehot_of(input int unsigned idx);
        logic [MaxN-1:0] v;
        v = '0;
        if (idx < MaxN) begin
            v[idx[3:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// ---------------------------------------------------------------------------------------------
// rr_onehot_arbiter_if: request/grant bundle between requesters and the arbiter.
//
// Signals:
//   req       [N]  request lines, bit i = requester i wants the resource
//   done      [1]  one-cycle release pulse from the current owner
//   gnt       [N]  registered grant, all zeros or exactly one-hot
//   gnt_valid [1]  high while gnt is non-zero
//   timeout   [1]  one-cycle pulse on a forced release (0 unless ARB_TIMEOUT_EN)
//
// Modports:
//   master - requester side (drives req/done)
//   slave  - arbiter side (drives gnt/gnt_valid/timeout)
// ---------------------------------------------------------------------------------------------
interface rr_onehot_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned N = DefaultN
) ();

    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// ---------------------------------------------------------------------------------------------
// rr_pick: combinational round-robin selector.
//
// Finds the first set bit of req scanning upward from ptr and wrapping N-1 -> 0.
// Works by rotating req so ptr lands at bit 0, taking the lowest set bit, then rotating the
// resulting index back. Reusable by any arbiter that keeps its own pointer.
//
// Ports:
//   req   [N]          input  request vector
//   ptr   [$clog2(N)]  input  highest-priority index (must be < N)
//   found [1]          output at least one request is set
//   idx   [$clog2(N)]  output selected index (0 when found is low)
// ---------------------------------------------------------------------------------------------
module rr_pick #(
    parameter  int unsigned N    = 4,
    localparam int unsigned PtrW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic            found,
    output logic [PtrW-1:0] idx
);

    logic [N-1:0]    rot;
    logic [PtrW:0]   src;
    logic [PtrW-1:0] sel;
    logic [PtrW:0]   back;

    always_comb begin
        rot  = '0;
        src  = '0;
        sel  = '0;
        back = '0;

        // rot[i] = req[(ptr + i) mod N]; one extra bit keeps the sum from overflowing.
        for (int i = 0; i < N; i++) begin
            src = {1'b0, ptr} + (PtrW + 1)'(i);
            if (src >= (PtrW + 1)'(N)) begin
                src = src - (PtrW + 1)'(N);
            end
            rot[i] = req[src[PtrW-1:0]];
        end

        // Lowest set bit of the rotated vector wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel = PtrW'(i);
            end
        end

        // Undo the rotation with an explicit wrap so non-power-of-2 N stays in range.
        back = {1'b0, ptr} + {1'b0, sel};
        if (back >= (PtrW + 1)'(N)) begin
            back = back - (PtrW + 1)'(N);
        end

        found = |rot;
        idx   = found ? back[PtrW-1:0] : '0;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------------------------
// rr_onehot_arbiter: round-robin arbiter feeding a one-hot-input priority encoder.
//
// Produces a registered grant that is always zero or exactly one-hot. A grant is held until
// the owner pulses done or drops its request; the priority pointer then moves to owner+1.
// Between two grants there is always at least one all-zero cycle.
//
// Parameters:
//   N        - number of requesters, 2..16
//   MAX_HOLD - forced-release limit in cycles (only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk  input   rising-edge clock
//   rst  input   synchronous active-high reset
//   bus  slave   req/done in, gnt/gnt_valid/timeout out (see rr_onehot_arbiter_if)
//
// Configuration macro:
//   ARB_TIMEOUT_EN - when defined, builds a hold counter that forces a release after
//                    MAX_HOLD non-released GRANT cycles and pulses timeout. When undefined,
//                    timeout is constant 0 and a grant may be held indefinitely.
// ---------------------------------------------------------------------------------------------
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = DefaultN,
    parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
    input logic                 clk,
    input logic                 rst,
    rr_onehot_arbiter_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(N);

    arb_state_e      state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;

    logic            pick_found;
    logic [PtrW-1:0] pick_idx;
    logic            release_req;
    logic [PtrW-1:0] ptr_after_owner;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // done and a dropped owner request on the same edge are one release.
    assign release_req     = bus.done | ~bus.req[owner_q];
    assign ptr_after_owner = (owner_q == PtrW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                // done is ignored here; only requests matter.
                if (pick_found) begin
                    state_d     = GRANT;
                    owner_d     = pick_idx;
                    gnt_d       = N'(onehot_of(32'(pick_idx)));
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = '0;
`endif
                end
            end

            GRANT: begin
                // Requests from non-owners are ignored while granted.
                if (release_req) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = ptr_after_owner;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HoldW'(MAX_HOLD)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = ptr_after_owner;
                    timeout_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= hold_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

    // The downstream encoder is undefined for multi-bit inputs.
    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_q));
    a_gnt_valid:   assert property (@(posedge clk) gnt_valid_q == (gnt_q != '0));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
module tb_rr_onehot_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;

    // Reference model state: which requester holds the resource, and the rotating pointer.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    rr_onehot_arbiter_if #(.N(N)) bus ();

    rr_onehot_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] g_exp, input logic v_exp,
                         input logic t_exp);
        tests++;
        if (bus.gnt !== g_exp || bus.gnt_valid !== v_exp || bus.timeout !== t_exp) begin
            fails++;
            $display("FAIL %s @%0t: got gnt=%b valid=%b timeout=%b, want gnt=%b valid=%b timeout=%b",
                     name, $time, bus.gnt, bus.gnt_valid, bus.timeout, g_exp, v_exp, t_exp);
        end
    endtask

    // Hand-computed expectation independent of the model.
    task automatic lit(input string name, input logic [N-1:0] g_exp, input logic t_exp);
        check(name, g_exp, g_exp != '0, t_exp);
    endtask

    // Advance the model one clock edge from the rules: first request from ptr upward wins,
    // release on done or dropped owner request, pointer moves past the released owner.
    task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic d);
        m_to = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!m_busy && rq[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_cnt   = 0;
                end
            end
        end else if (d || !rq[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == MAX_HOLD) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
            m_to   = 1'b1;
        end else begin
            m_cnt++;
        end
`endif
    endtask

    // Called at a negedge: drive inputs, take one edge, compare against the model.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic d);
        logic [N-1:0] exp_g;
        rst      = r;
        bus.req  = rq;
        bus.done = d;
        @(posedge clk);
        model_edge(r, rq, d);
        @(negedge clk);
        exp_g = '0;
        if (m_busy) exp_g[m_owner] = 1'b1;
        check("model", exp_g, m_busy, m_to);
    endtask

    initial begin
        logic [N-1:0] rq;
        bus.req  = '0;
        bus.done = 1'b0;
        @(negedge clk);

        // Reset and single request.
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        lit("reset", 4'b0000, 0);
        step(0, 4'b0001, 0);
        lit("single_grant", 4'b0001, 0);
        step(0, 4'b0001, 1);
        lit("single_release", 4'b0000, 0);
        step(0, 4'b0010, 0);
        lit("ptr_after_single", 4'b0010, 0);

        // Full contention rotation with wrap.
        step(1, 4'b1111, 0);
        step(0, 4'b1111, 0); lit("rot0", 4'b0001, 0);
        step(0, 4'b1111, 1); lit("rot1", 4'b0000, 0);
        step(0, 4'b1111, 0); lit("rot2", 4'b0010, 0);
        step(0, 4'b1111, 1); lit("rot3", 4'b0000, 0);
        step(0, 4'b1111, 0); lit("rot4", 4'b0100, 0);
        step(0, 4'b1111, 1); lit("rot5", 4'b0000, 0);
        step(0, 4'b1111, 0); lit("rot6", 4'b1000, 0);
        step(0, 4'b1111, 1); lit("rot7", 4'b0000, 0);
        step(0, 4'b1111, 0); lit("rot8_wrap", 4'b0001, 0);

        // Release by dropping the request.
        step(1, 4'b0000, 0);
        step(0, 4'b0100, 0); lit("drop_grant", 4'b0100, 0);
        step(0, 4'b0000, 0); lit("drop_release", 4'b0000, 0);
        step(0, 4'b0011, 0); lit("drop_next_from_ptr3", 4'b0001, 0);

        // Non-owner request changes and stray done in IDLE.
        step(1, 4'b0000, 0);
        step(0, 4'b0010, 0); lit("ign_grant", 4'b0010, 0);
        step(0, 4'b1011, 0); lit("ign_toggle_a", 4'b0010, 0);
        step(0, 4'b0010, 0); lit("ign_toggle_b", 4'b0010, 0);
        step(0, 4'b1010, 0); lit("ign_toggle_c", 4'b0010, 0);
        step(0, 4'b0010, 1); lit("ign_release", 4'b0000, 0);
        step(0, 4'b0000, 1); lit("stray_done", 4'b0000, 0);
        step(0, 4'b0000, 1);
        step(0, 4'b1111, 0); lit("ptr2_kept", 4'b0100, 0);

        // Same-edge done and dropped request: one release, pointer advances once.
        step(0, 4'b1011, 1); lit("dual_release", 4'b0000, 0);
        step(0, 4'b1111, 0); lit("dual_next", 4'b1000, 0);

        // Reset mid-grant: no priority credit for the interrupted owner.
        step(1, 4'b1111, 0); lit("reset_mid", 4'b0000, 0);
        step(0, 4'b1111, 0); lit("after_reset_mid", 4'b0001, 0);

        // Long hold.
        step(1, 4'b0000, 0);
        step(0, 4'b0001, 0);
        for (int i = 0; i < 8; i++) step(0, 4'b0001, 0);
        lit("hold_9_cycles", 4'b0001, 0);
`ifdef ARB_TIMEOUT_EN
        step(0, 4'b0001, 0); lit("timeout_release", 4'b0000, 1);
        step(0, 4'b0011, 0); lit("timeout_next", 4'b0010, 0);
`else
        for (int i = 0; i < 12; i++) step(0, 4'b0001, 0);
        lit("hold_indefinite", 4'b0001, 0);
`endif

        // Randomized traffic; owner tends to keep its request so grants last a while.
        step(1, 4'b0000, 0);
        for (int i = 0; i < 1500; i++) begin
            rq = N'($urandom_range(0, (1 << N) - 1));
            if (m_busy && ($urandom_range(0, 3) != 0)) rq[m_owner] = 1'b1;
            step(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
